// File: rtl/relu_width_parameterized.sv
// rtl/relu_width_parameterized.sv - registered ReLU for IEEE-754 or signed integer words with valid/ready handshake
module relu_width_parameterized #(
  parameter int WIDTH    = 64,
  parameter int IS_FLOAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] num,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] relu_num,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             clipped,
  output logic             nan_seen
);

  localparam int EXP_W  = (WIDTH == 16) ? 5 : (WIDTH == 32) ? 8 : 11;
  localparam int MANT_W = WIDTH - 1 - EXP_W;
  // Positive quiet NaN: exponent all ones, only the mantissa MSB set.
  localparam logic [WIDTH-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

  logic [EXP_W-1:0]  exp_field;
  logic [MANT_W-1:0] mant_field;
  logic              is_nan;
  logic              is_neg;
  logic              accept;
  logic [WIDTH-1:0]  next_num;

  assign exp_field  = num[WIDTH-2 -: EXP_W];
  assign mant_field = num[MANT_W-1:0];
  assign is_nan     = (IS_FLOAT != 0) && (&exp_field) && (|mant_field);
  assign is_neg     = num[WIDTH-1] && !is_nan;
  assign next_num   = is_nan ? CANON_NAN : (is_neg ? '0 : num);

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      relu_num  <= '0;
      clipped   <= 1'b0;
      nan_seen  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      relu_num  <= next_num;
      clipped   <= is_neg;
      nan_seen  <= is_nan;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_relu_width_parameterized.sv
// tb/tb_relu_width_parameterized.sv - randomized bench for relu_width_parameterized against a reference model
module tb_relu_width_parameterized;

  logic        clk;
  logic        rst_n;
  logic [63:0] f_num;
  logic        f_in_valid, f_in_ready, f_out_valid, f_out_ready, f_clipped, f_nan_seen;
  logic [63:0] f_relu_num;
  logic [31:0] i_num;
  logic        i_in_valid, i_in_ready, i_out_valid, i_out_ready, i_clipped, i_nan_seen;
  logic [31:0] i_relu_num;

  int total = 0;
  int bad   = 0;

  // Expected contents of each DUT's output register
  logic        ef_v, ef_c, ef_n, ei_v, ei_c, ei_n;
  logic [63:0] ef_d, ei_d;

  relu_width_parameterized #(.WIDTH(64), .IS_FLOAT(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .num(f_num), .in_valid(f_in_valid), .in_ready(f_in_ready),
    .relu_num(f_relu_num), .out_valid(f_out_valid), .out_ready(f_out_ready),
    .clipped(f_clipped), .nan_seen(f_nan_seen)
  );

  relu_width_parameterized #(.WIDTH(32), .IS_FLOAT(0)) dut_i (
    .clk(clk), .rst_n(rst_n), .num(i_num), .in_valid(i_in_valid), .in_ready(i_in_ready),
    .relu_num(i_relu_num), .out_valid(i_out_valid), .out_ready(i_out_ready),
    .clipped(i_clipped), .nan_seen(i_nan_seen)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void relu_ref(input logic [63:0] x, input int w, input bit fl,
                                   output logic [63:0] r, output logic c, output logic n);
    longint unsigned v, e, m, one, emax;
    int ew, mw;
    v    = x;
    one  = 1;
    ew   = (w == 16) ? 5 : (w == 32) ? 8 : 11;
    mw   = w - 1 - ew;
    emax = (one << ew) - 1;
    e    = (v >> mw) & emax;
    m    = v & ((one << mw) - 1);
    c = 1'b0;
    n = 1'b0;
    if (fl && e == emax && m != 0) begin
      r = (emax << mw) | (one << (mw - 1));
      n = 1'b1;
    end else if (((v >> (w - 1)) & one) == one) begin
      r = 64'd0;
      c = 1'b1;
    end else begin
      r = v;
    end
  endfunction

  function automatic logic [63:0] rand_f64();
    logic [63:0] w;
    w = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0: w[62:52] = 11'h7FF;                                  // NaN or infinity
      1: w = {w[63], 11'h7FF, 51'd0, 1'b1};                   // smallest-payload NaN
      2: w = {w[63], 63'd0};                                  // +/-0
      3: w = {w[63], 11'h7FF, 52'd0};                         // +/-infinity
      4: w[62:52] = 11'd0;                                    // denormal
      default: ;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] rand_i32();
    case ($urandom_range(0, 4))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  // One clock cycle for both DUTs: apply inputs, check in_ready, clock, check outputs.
  task automatic cycle(input bit fv, input logic [63:0] fn, input bit fr,
                       input bit iv, input logic [31:0] inn, input bit ir);
    bit fa, ia;
    f_in_valid = fv; f_num = fn;  f_out_ready = fr;
    i_in_valid = iv; i_num = inn; i_out_ready = ir;
    #1;
    check("f_in_ready", f_in_ready, !ef_v || fr);
    check("i_in_ready", i_in_ready, !ei_v || ir);
    fa = fv && (!ef_v || fr);
    ia = iv && (!ei_v || ir);
    @(posedge clk);
    if (fa) begin relu_ref(fn, 64, 1'b1, ef_d, ef_c, ef_n); ef_v = 1'b1; end
    else if (fr) ef_v = 1'b0;
    if (ia) begin relu_ref({32'd0, inn}, 32, 1'b0, ei_d, ei_c, ei_n); ei_v = 1'b1; end
    else if (ir) ei_v = 1'b0;
    #1;
    check("f_out_valid", f_out_valid, ef_v);
    check("i_out_valid", i_out_valid, ei_v);
    if (ef_v) begin
      check("f_relu_num", f_relu_num, ef_d);
      check("f_clipped",  f_clipped,  ef_c);
      check("f_nan_seen", f_nan_seen, ef_n);
    end
    if (ei_v) begin
      check("i_relu_num", i_relu_num, ei_d);
      check("i_clipped",  i_clipped,  ei_c);
      check("i_nan_seen", i_nan_seen, 1'b0);
    end
  endtask

  logic [63:0] dir_f [9];
  logic [31:0] dir_i [9];

  initial begin
    rst_n = 1'b0;
    f_in_valid = 1'b0; f_num = '0; f_out_ready = 1'b1;
    i_in_valid = 1'b0; i_num = '0; i_out_ready = 1'b1;
    ef_v = 1'b0; ef_d = '0; ef_c = 1'b0; ef_n = 1'b0;
    ei_v = 1'b0; ei_d = '0; ei_c = 1'b0; ei_n = 1'b0;
    #2;
    check("rst_f_out_valid", f_out_valid, 1'b0);
    check("rst_f_relu_num",  f_relu_num, 64'd0);
    check("rst_f_flags",     {f_clipped, f_nan_seen}, 2'b00);
    check("rst_i_out_valid", i_out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_f_in_ready", f_in_ready, 1'b1);
    check("rst_i_in_ready", i_in_ready, 1'b1);
    @(posedge clk);
    #1;

    dir_f = '{64'h3FF0000000000000, 64'h3FB999999999999A, 64'h0, 64'hBFB999999999999A,
              64'hBFF0000000000000, 64'h8000000000000000, 64'hFFF0000000000001,
              64'h7FF0000000000000, 64'h0000000000000001};
    dir_i = '{32'd5, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd0, 32'd1,
              32'hFFFFFFFE, 32'h40000000, 32'hC0000000};
    foreach (dir_f[k]) cycle(1'b1, dir_f[k], 1'b1, 1'b1, dir_i[k], 1'b1);
    cycle(1'b0, 'x, 1'b1, 1'b0, 'x, 1'b1);

    // Backpressure: one accepted word, three stalled cycles, then take-and-load on one edge
    cycle(1'b1, 64'hC000000000000000, 1'b1, 1'b1, 32'd7, 1'b1);
    for (int k = 0; k < 3; k++)
      cycle(1'b1, 64'h4000000000000000, 1'b0, 1'b1, 32'd9, 1'b0);
    cycle(1'b1, 64'h4000000000000000, 1'b1, 1'b1, 32'd9, 1'b1);
    cycle(1'b0, 'x, 1'b1, 1'b0, 'x, 1'b1);

    for (int k = 0; k < 600; k++) begin
      bit fv, iv;
      fv = ($urandom_range(0, 3) != 0);
      iv = ($urandom_range(0, 3) != 0);
      cycle(fv, fv ? rand_f64() : 64'bx, ($urandom_range(0, 2) != 0),
            iv, iv ? rand_i32() : 32'bx, ($urandom_range(0, 2) != 0));
    end

    // Reset while a result is pending and stalled
    cycle(1'b1, 64'hFFF8000000000123, 1'b0, 1'b1, 32'h12345678, 1'b0);
    cycle(1'b0, 'x, 1'b0, 1'b0, 'x, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_f_out_valid", f_out_valid, 1'b0);
    check("midrst_f_relu_num",  f_relu_num, 64'd0);
    check("midrst_f_flags",     {f_clipped, f_nan_seen}, 2'b00);
    check("midrst_i_out_valid", i_out_valid, 1'b0);
    check("midrst_i_relu_num",  i_relu_num, 32'd0);
    ef_v = 1'b0; ei_v = 1'b0;
    rst_n = 1'b1;
    #1;
    check("midrst_f_in_ready", f_in_ready, 1'b1);
    check("midrst_i_in_ready", i_in_ready, 1'b1);
    @(posedge clk);
    #1;
    cycle(1'b0, 'x, 1'b1, 1'b0, 'x, 1'b1);
    cycle(1'b1, 64'h7FF0000000000000, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
